// File: rtl/up_down_counter_param.sv
// up_down_counter_param
//
// General-purpose up/down counter. Counts modulo MAX_VAL+1, with a count
// enable, a synchronous parallel load, and a choice of wrapping or
// saturating at the count limits. It also provides a combinational
// terminal-count flag and a registered one-cycle wrap-event pulse.
//
// Parameters:
//   WIDTH    counter width in bits (2..32)
//   MAX_VAL  highest count value, 1 <= MAX_VAL <= 2**WIDTH-1
//
// Ports:
//   clk       rising-edge clock for all state
//   rst       asynchronous active-low reset (clears count and wrap)
//   en        count enable; the counter holds when low
//   up_down   direction: 1 = increment, 0 = decrement
//   sat       limit mode: 0 = wrap, 1 = saturate
//   load      synchronous load strobe; takes priority over en
//   load_val  value to load, clamped to MAX_VAL
//   step      (only with UDC_STEP_EN) per-cycle step amount, clamped to
//             MAX_VAL; 0 holds the count
//   count     registered count value
//   tc        terminal count: at MAX_VAL when counting up, at 0 when
//             counting down
//   wrap      registered pulse, high in the cycle the wrapped count appears
//
// Optional feature macro: UDC_STEP_EN. When it is defined the step input
// is present. When it is undefined the step is fixed at 1.

module up_down_counter_param #(
  parameter int unsigned     WIDTH   = 8,
  parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_down,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef UDC_STEP_EN
  input  logic [WIDTH-1:0] step,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  // The arithmetic is one bit wider than the counter. As a result,
  // count+step and the modulus MAX_VAL+1 never overflow, even when
  // MAX_VAL = 2**WIDTH-1.
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   ONE_EXT = (WIDTH+1)'(1);
  localparam logic [WIDTH:0]   MOD_EXT = MAX_EXT + ONE_EXT;
  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH:0]   count_ext;
  logic [WIDTH:0]   load_ext;
  logic [WIDTH:0]   step_ext;
  logic [WIDTH:0]   sum_ext;

  // Widened operands. The step is clamped to MAX_VAL so that
  // MAX_EXT - step_ext below can never go negative.
  always_comb begin
    count_ext = {1'b0, count_q};
    load_ext  = {1'b0, load_val};
`ifdef UDC_STEP_EN
    step_ext  = ({1'b0, step} > MAX_EXT) ? MAX_EXT : {1'b0, step};
`else
    step_ext  = ONE_EXT;
`endif
    sum_ext   = count_ext + step_ext;
  end

  // Next-state logic. Load has priority over counting, and counting has
  // priority over holding. The wrap pulse is high only on an actual
  // wrap, so every other path leaves it at its default of 0.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = (load_ext > MAX_EXT) ? MAX_Q : load_val;
    end else if (en) begin
      if (up_down) begin
        if (sum_ext > MAX_EXT) begin
          if (sat) begin
            count_d = MAX_Q;
          end else begin
            count_d = WIDTH'(sum_ext - MOD_EXT);
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = WIDTH'(sum_ext);
        end
      end else begin
        if (step_ext > count_ext) begin
          if (sat) begin
            count_d = '0;
          end else begin
            // count + (MAX_VAL+1) - step. The terms are ordered so that
            // no intermediate value underflows.
            count_d = WIDTH'(count_ext + (MAX_EXT - step_ext) + ONE_EXT);
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = WIDTH'(count_ext - step_ext);
        end
      end
    end
  end

  // State register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;

  // Terminal count is deliberately combinational and independent of en
  // and sat. This lets it drive the enable of a cascaded counter in the
  // same cycle.
  assign tc = up_down ? (count_q == MAX_Q) : (count_q == '0);

endmodule

// File: tb/tb_up_down_counter_param.sv
// tb_up_down_counter_param
//
// Self-checking bench for up_down_counter_param with WIDTH=4, MAX_VAL=9.
// Each stimulus cycle pushes the expected count, wrap and tc values onto a
// scoreboard queue. After the clock edge, the entry is popped and compared
// with the DUT outputs. When UDC_STEP_EN is defined, the step input is
// exercised as well.

module tb_up_down_counter_param;

  localparam int WIDTH = 4;
  localparam int MAXV  = 9;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic             up_down = 1'b0;
  logic             sat = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic [WIDTH-1:0] step = 4'd1;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string tag;
    int    count;
    int    wrap;
    int    tc;
  } exp_t;

  exp_t sb_q[$];
  int   m_count = 0;

  up_down_counter_param #(
    .WIDTH  (WIDTH),
    .MAX_VAL(MAXV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .up_down (up_down),
    .sat     (sat),
    .load    (load),
    .load_val(load_val),
`ifdef UDC_STEP_EN
    .step    (step),
`endif
    .count   (count),
    .tc      (tc),
    .wrap    (wrap)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Drives one cycle of inputs and predicts the result from the
  // behavioural rules. Then waits for the edge and compares the DUT
  // outputs against the popped scoreboard entry.
  task automatic applyStimulus(input string tag, input logic e, input logic ud, input logic s,
                               input logic ld, input int lv, input int st);
    exp_t x;
    int   stp;
    int   nw;
    en       = e;
    up_down  = ud;
    sat      = s;
    load     = ld;
    load_val = lv[WIDTH-1:0];
    step     = st[WIDTH-1:0];
    stp = (st > MAXV) ? MAXV : st;
`ifndef UDC_STEP_EN
    stp = 1;
`endif
    nw = 0;
    if (ld) begin
      m_count = (lv > MAXV) ? MAXV : lv;
    end else if (e) begin
      if (ud) begin
        if (m_count + stp > MAXV) begin
          if (s) m_count = MAXV;
          else begin
            m_count = m_count + stp - (MAXV + 1);
            nw = 1;
          end
        end else m_count = m_count + stp;
      end else begin
        if (stp > m_count) begin
          if (s) m_count = 0;
          else begin
            m_count = m_count + (MAXV + 1) - stp;
            nw = 1;
          end
        end else m_count = m_count - stp;
      end
    end
    x.tag   = tag;
    x.count = m_count;
    x.wrap  = nw;
    x.tc    = ud ? int'(m_count == MAXV) : int'(m_count == 0);
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    checkOutput({x.tag, ".count"}, 32'(count), 32'(x.count));
    checkOutput({x.tag, ".wrap"},  32'(wrap),  32'(x.wrap));
    checkOutput({x.tag, ".tc"},    32'(tc),    32'(x.tc));
  endtask

  initial begin
    // Asynchronous reset is visible before any clock edge.
    #3;
    checkOutput("rst0.count", 32'(count), 32'd0);
    checkOutput("rst0.wrap",  32'(wrap),  32'd0);
    checkOutput("rst0.tc",    32'(tc),    32'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_count = 0;

    // Count up 1..9; tc rises at 9.
    for (int i = 1; i <= MAXV; i++) applyStimulus("up", 1, 1, 0, 0, 0, 1);
    // Up wrap, then a normal increment.
    applyStimulus("upwrap", 1, 1, 0, 0, 0, 1);
    applyStimulus("upafter", 1, 1, 0, 0, 0, 1);

    // Down wrap from 0.
    applyStimulus("ld0", 0, 0, 0, 1, 0, 1);
    applyStimulus("dnwrap", 1, 0, 0, 0, 0, 1);
    // Down saturate at 0.
    applyStimulus("ld0b", 0, 0, 1, 1, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus("dnsat", 1, 0, 1, 0, 0, 1);
    // Up saturate at MAX.
    applyStimulus("ld9", 0, 1, 1, 1, 9, 1);
    applyStimulus("upsat", 1, 1, 1, 0, 0, 1);

    // Load priority over enable, load clamping, hold.
    applyStimulus("ld5", 1, 1, 0, 1, 5, 1);
    applyStimulus("ld3en", 1, 1, 0, 1, 3, 1);
    applyStimulus("ld14", 1, 0, 0, 1, 14, 1);
    for (int i = 0; i < 4; i++) applyStimulus("hold", 0, i[0], i[1], 0, 0, 1);

    // Direction change without a dead cycle.
    applyStimulus("ld4", 0, 1, 0, 1, 4, 1);
    applyStimulus("dir5", 1, 1, 0, 0, 0, 1);
    applyStimulus("dir6", 1, 1, 0, 0, 0, 1);
    applyStimulus("dir5d", 1, 0, 0, 0, 0, 1);
    applyStimulus("dir4d", 1, 0, 0, 0, 0, 1);

    // tc follows up_down combinationally at 9 and at 0.
    applyStimulus("ld9tc", 0, 1, 0, 1, 9, 1);
    up_down = 1'b0;
    #1;
    checkOutput("tc9.dn", 32'(tc), 32'd0);
    up_down = 1'b1;
    #1;
    checkOutput("tc9.up", 32'(tc), 32'd1);
    applyStimulus("ld0tc", 0, 1, 0, 1, 0, 1);
    checkOutput("tc0.up", 32'(tc), 32'd0);
    up_down = 1'b0;
    #1;
    checkOutput("tc0.dn", 32'(tc), 32'd1);

    // Mid-count reset with a pending load: clears asynchronously and the
    // load is lost.
    applyStimulus("ld7", 0, 1, 0, 1, 7, 1);
    applyStimulus("up8", 1, 1, 0, 0, 0, 1);
    load     = 1'b1;
    load_val = 4'd3;
    rst      = 1'b0;
    #1;
    checkOutput("rstmid.count", 32'(count), 32'd0);
    checkOutput("rstmid.wrap",  32'(wrap),  32'd0);
    @(posedge clk);
    #1;
    checkOutput("rsthold.count", 32'(count), 32'd0);
    load = 1'b0;
    rst  = 1'b1;
    m_count = 0;

    // Wrap pulse lasts exactly one cycle after a down wrap.
    applyStimulus("dnwrap2", 1, 0, 0, 0, 0, 1);
    applyStimulus("dnafter", 1, 0, 0, 0, 0, 1);

`ifdef UDC_STEP_EN
    // Step-size behaviour.
    applyStimulus("st.ld8", 0, 1, 0, 1, 8, 4);
    applyStimulus("st.upwrap", 1, 1, 0, 0, 0, 4);
    applyStimulus("st.ld1", 0, 0, 0, 1, 1, 4);
    applyStimulus("st.dnwrap", 1, 0, 0, 0, 0, 4);
    applyStimulus("st.ld8s", 0, 1, 1, 1, 8, 4);
    applyStimulus("st.upsat", 1, 1, 1, 0, 0, 4);
    applyStimulus("st.zero", 1, 1, 0, 0, 0, 0);
    applyStimulus("st.big", 1, 0, 0, 0, 0, 15);
`endif

    // Randomised mix of all modes.
    for (int i = 0; i < 300; i++) begin
      applyStimulus("rand", $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end

    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard: got %0d entries left expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
